spi_cmd_ram: RTL

- Parametrised command-decoded RAM slave behind the SPI slave front end.
- Each rx_valid word carries a 2-bit opcode plus a DATA_W payload: set write address, write data, set read address, read data.
- Adds a valid/ready read-return handshake, address-sequencing checks with an error pulse, and out-of-range detection.
- Optional address auto-increment enables burst transfers.

---
 rtl/spi_ram_pkg.sv | 15 +
 rtl/spi_ram_mem.sv | 33 +++
 rtl/spi_cmd_ram.sv | 127 ++++++++++++
 3 files changed

// File: rtl/spi_ram_pkg.sv
// spi_ram_pkg: shared definitions for the SPI command-decoded RAM slave.
//   opcode_e : 2-bit command opcode carried in the top bits of each rx word
//   OP_W     : opcode field width
package spi_ram_pkg;

  localparam int OP_W = 2;

  typedef enum logic [OP_W-1:0] {
    OP_SET_WR  = 2'b00,
    OP_WR_DATA = 2'b01,
    OP_SET_RD  = 2'b10,
    OP_RD_DATA = 2'b11
  } opcode_e;

endpackage

// File: rtl/spi_ram_mem.sv
// spi_ram_mem: plain storage array with one synchronous write port and one
// synchronous read port. No reset; the caller qualifies addresses.
//   clk     in  rising-edge clock
//   wr_en   in  write strobe
//   wr_addr in  write address
//   wr_data in  write data
//   rd_en   in  read strobe; rd_data updates only when set, else holds
//   rd_addr in  read address
//   rd_data out registered read data
module spi_ram_mem #(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 8,
  parameter int MEM_DEPTH = 256
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [MEM_DEPTH];

  // NOTE: storage has no reset so it maps onto RAM macros; contents after
  // power-up are undefined and must be written before being relied on.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/spi_cmd_ram.sv
// spi_cmd_ram: command-decoded RAM slave behind an SPI slave front end.
// Each rx_valid word is {opcode, payload}: set write address, write data,
// set read address, read data. Read data returns on a valid/ready port.
// Rejected commands (unset address, out-of-range address, busy return slot)
// produce a one-cycle seq_err pulse on the cycle after the command edge.
// Optional macro SPI_RAM_AUTO_INC_EN: accepted data commands post-increment
// their address modulo MEM_DEPTH.
//   clk      in  rising-edge clock
//   rst_n    in  asynchronous active-low reset
//   rx_valid in  command word valid, one cycle per word
//   din      in  {opcode[1:0], payload[DATA_W-1:0]}
//   tx_ready in  consumer accepts dout this cycle
//   dout     out read return data
//   tx_valid out dout valid, held until accepted
//   seq_err  out one-cycle pulse: command rejected
module spi_cmd_ram
  import spi_ram_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 8,
  parameter int MEM_DEPTH = 256
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               rx_valid,
  input  logic [DATA_W+1:0]  din,
  input  logic               tx_ready,
  output logic [DATA_W-1:0]  dout,
  output logic               tx_valid,
  output logic               seq_err
);

  opcode_e             op;
  logic [DATA_W-1:0]   payload;
  logic [ADDR_W-1:0]   addr_wr, addr_rd;
  logic                wr_set, rd_set;
  logic                wr_ok, rd_ok, reject;
  logic                dout_loaded;
  logic [DATA_W-1:0]   rd_data;

  assign op      = opcode_e'(din[DATA_W+OP_W-1 -: OP_W]);
  assign payload = din[DATA_W-1:0];

`ifdef SPI_RAM_AUTO_INC_EN
  function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a);
    return (int'(a) == MEM_DEPTH - 1) ? '0 : a + 1'b1;
  endfunction
`endif

  // NOTE: every signal driven here gets a default first, so no path through
  // the case leaves it unassigned and no latch is inferred.
  always_comb begin
    wr_ok  = 1'b0;
    rd_ok  = 1'b0;
    reject = 1'b0;
    if (rx_valid) begin
      unique case (op)
        OP_WR_DATA: begin
          if (wr_set && int'(addr_wr) < MEM_DEPTH) wr_ok = 1'b1;
          else                                     reject = 1'b1;
        end
        OP_RD_DATA: begin
          // The return slot is busy only if a pending word is not being
          // drained on this same edge.
          if (rd_set && int'(addr_rd) < MEM_DEPTH && !(tx_valid && !tx_ready))
            rd_ok = 1'b1;
          else
            reject = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // NOTE: all state here uses non-blocking assignments so every register
  // samples pre-edge values and simulation matches the synthesized flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_wr     <= '0;
      addr_rd     <= '0;
      wr_set      <= 1'b0;
      rd_set      <= 1'b0;
      tx_valid    <= 1'b0;
      seq_err     <= 1'b0;
      dout_loaded <= 1'b0;
    end else begin
      seq_err <= reject;
      if (rx_valid && op == OP_SET_WR) begin
        addr_wr <= payload[ADDR_W-1:0];
        wr_set  <= 1'b1;
      end
      if (rx_valid && op == OP_SET_RD) begin
        addr_rd <= payload[ADDR_W-1:0];
        rd_set  <= 1'b1;
      end
`ifdef SPI_RAM_AUTO_INC_EN
      if (wr_ok) addr_wr <= next_addr(addr_wr);
      if (rd_ok) addr_rd <= next_addr(addr_rd);
`endif
      if (rd_ok) begin
        tx_valid    <= 1'b1;
        dout_loaded <= 1'b1;
      end else if (tx_valid && tx_ready) begin
        tx_valid <= 1'b0;
      end
    end
  end

  // The RAM read register has no reset; mask it until the first accepted
  // read so dout reads 0 out of reset.
  assign dout = dout_loaded ? rd_data : '0;

  spi_ram_mem #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .MEM_DEPTH(MEM_DEPTH)
  ) u_mem (
    .clk    (clk),
    .wr_en  (wr_ok),
    .wr_addr(addr_wr),
    .wr_data(payload),
    .rd_en  (rd_ok),
    .rd_addr(addr_rd),
    .rd_data(rd_data)
  );

endmodule
